// File: rtl/tdc_uart_pkg.sv
// Shared types and constants for the TDC result UART uplink.
// Build option: TDC_UART_CHECKSUM_EN appends an XOR checksum byte.
package tdc_uart_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

`ifdef TDC_UART_CHECKSUM_EN
    localparam int FRAME_BYTES = 5;
`else
    localparam int FRAME_BYTES = 4;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } tx_state_e;

    function automatic logic [7:0] frame_byte(
        input logic [19:0] d,
        input logic [2:0]  idx
    );
        logic [7:0] b;
        b = HDR_BYTE;
        case (idx)
            3'd1: b = {4'h0, d[19:16]};
            3'd2: b = d[15:8];
            3'd3: b = d[7:0];
`ifdef TDC_UART_CHECKSUM_EN
            3'd4: b = {4'h0, d[19:16]} ^ d[15:8] ^ d[7:0];
`endif
            default: b = HDR_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter; accepts a new byte during the last stop-bit
// cycle so consecutive bytes run back-to-back.
module uart_byte_tx #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [9:0]    sh_q;
    logic          busy_q;
    logic          last;

    assign last = busy_q && bit_q == 4'd9 && cnt_q == CW'(CLK_DIV - 1);
    // Early by one cycle so the frame FSM can present the next byte in time
    assign done = busy_q && bit_q == 4'd9 && cnt_q == CW'(CLK_DIV - 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '1;
        end else if (start && (!busy_q || last)) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= {1'b1, data, 1'b0};
        end else if (busy_q) begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
                cnt_q <= '0;
                if (bit_q == 4'd9) begin
                    busy_q <= 1'b0;
                end else begin
                    bit_q <= bit_q + 4'd1;
                    sh_q  <= {1'b1, sh_q[9:1]};
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign tx   = busy_q ? sh_q[0] : 1'b1;
    assign busy = busy_q;

endmodule

// File: rtl/tdc_result_uart.sv
// TDC result uplink: edge capture, result FIFO, framed UART transmit.
// Build option: TDC_UART_CHECKSUM_EN (see tdc_uart_pkg).
module tdc_result_uart
    import tdc_uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [19:0]                 in_data,
    input  logic                        in_dval_n,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  ovf_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic        dval_q;
    logic        armed_q;
    logic        fall;
    logic        push_q;
    logic [19:0] cap_q;

    // armed_q blocks a false edge when in_dval_n is low at reset release
    assign fall = armed_q & dval_q & ~in_dval_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dval_q  <= 1'b1;
            armed_q <= 1'b0;
            push_q  <= 1'b0;
            cap_q   <= '0;
        end else begin
            dval_q  <= in_dval_n;
            armed_q <= armed_q | in_dval_n;
            push_q  <= fall;
            if (fall) begin
                cap_q <= in_data;
            end
        end
    end

    logic [19:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          pop;

    assign level = wr_ptr - rd_ptr;
    assign full  = level == LW'(FIFO_DEPTH);
    assign empty = level == '0;
    assign wr_en = push_q & ~full;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= cap_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push_q && full && ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign fifo_level = level;

    tx_state_e   state_q;
    tx_state_e   state_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic [19:0] frame_q;
    logic        start;
    logic        done;
    logic [7:0]  cur_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (pop) begin
                frame_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                start   = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (done) begin
                    if (idx_q == 3'(FRAME_BYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cur_byte = frame_byte(frame_q, idx_q);

    uart_byte_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_byte_tx (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .data (cur_byte),
        .tx   (tx),
        .busy (tx_busy),
        .done (done)
    );

endmodule

// File: tb/tb_tdc_result_uart.sv
// Self-checking bench for tdc_result_uart: UART line decoder plus
// expected-result queue derived from the frame format.
module tb_tdc_result_uart;

    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 16;
`ifdef TDC_UART_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] in_data = '0;
    logic        in_dval_n = 1'b1;
    logic        tx;
    logic        tx_busy;
    logic [4:0]  fifo_level;
    logic [7:0]  ovf_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  rx_q[$];
    logic [19:0] exp_q[$];

    tdc_result_uart #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dval_n (in_dval_n),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_level(fifo_level),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int unsigned v, input int k);
        int unsigned hi, mid, lo;
        hi  = (v >> 16) % 16;
        mid = (v >> 8) % 256;
        lo  = v % 256;
        case (k)
            0: return 8'hA5;
            1: return 8'(hi);
            2: return 8'(mid);
            3: return 8'(lo);
            default: return 8'(hi ^ mid ^ lo);
        endcase
    endfunction

    // UART line decoder: samples mid-bit, aborts bytes cut by reset
    initial begin : mon
        logic [7:0] b;
        logic       ok;
        logic       sb;
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                ok = 1'b1;
                for (int i = 0; i < CLK_DIV / 2; i++) begin
                    @(negedge clk);
                    if (!rst) ok = 1'b0;
                end
                if (tx !== 1'b0) ok = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    for (int i = 0; i < CLK_DIV; i++) begin
                        @(negedge clk);
                        if (!rst) ok = 1'b0;
                    end
                    b[j] = tx;
                end
                for (int i = 0; i < CLK_DIV; i++) begin
                    @(negedge clk);
                    if (!rst) ok = 1'b0;
                end
                sb = tx;
                if (ok) begin
                    rx_q.push_back(b);
                    check("stop_bit", 32'(sb), 32'd1);
                end
            end
        end
    end

    task automatic send(input logic [19:0] d, input int low, input int gap);
        @(negedge clk);
        in_data   = d;
        in_dval_n = 1'b0;
        repeat (low) @(negedge clk);
        in_dval_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int idle = 0;
        int t = 0;
        while (idle < 4 && t < bound) begin
            @(negedge clk);
            t++;
            idle = (!tx_busy && fifo_level == 0) ? idle + 1 : 0;
        end
        n_tests++;
        if (t >= bound) begin
            n_fail++;
            $display("FAIL idle_timeout: got busy after %0d cycles, want idle", t);
        end
    endtask

    task automatic check_rx(input string name);
        logic [19:0] v;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            for (int k = 0; k < NB; k++) begin
                if (rx_q.size() == 0) begin
                    check({name, "_missing"}, 32'd0, 32'd1);
                end else begin
                    check(name, 32'(rx_q.pop_front()), 32'(exp_byte(32'(v), k)));
                end
            end
        end
        check({name, "_extra"}, 32'(rx_q.size()), 32'd0);
        rx_q.delete();
    endtask

    typedef struct {
        logic [19:0] d;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cnt;
        int t;
        int n;
        logic [7:0] eb[5];

        tbl[0] = '{20'hABCDE, 8'h0A, 8'hBC, 8'hDE};
        tbl[1] = '{20'h12345, 8'h01, 8'h23, 8'h45};
        tbl[2] = '{20'h00000, 8'h00, 8'h00, 8'h00};
        tbl[3] = '{20'hFFFFF, 8'h0F, 8'hFF, 8'hFF};
        tbl[4] = '{20'h80001, 8'h08, 8'h00, 8'h01};
        tbl[5] = '{20'h5A5A5, 8'h05, 8'hA5, 8'hA5};

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(ovf_cnt), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            eb[0] = 8'hA5;
            eb[1] = tbl[v].b1;
            eb[2] = tbl[v].b2;
            eb[3] = tbl[v].b3;
            eb[4] = tbl[v].b1 ^ tbl[v].b2 ^ tbl[v].b3;
            cnt = 0;
            t = 0;
            fork
                send(tbl[v].d, 16, 4);
                begin
                    while (!tx_busy && t < 500) begin
                        @(negedge clk);
                        t++;
                    end
                    while (tx_busy && cnt < 2000) begin
                        @(negedge clk);
                        cnt++;
                    end
                end
            join
            check("busy_len", 32'(cnt), 32'(NB * 10 * CLK_DIV));
            wait_idle(2000);
            for (int k = 0; k < NB; k++) begin
                if (rx_q.size() == 0) check("vec_missing", 32'd0, 32'd1);
                else check("vec_byte", 32'(rx_q.pop_front()), 32'(eb[k]));
            end
            check("vec_extra", 32'(rx_q.size()), 32'd0);
            rx_q.delete();
        end

        send(20'h0F0F0, 40, 4);
        exp_q.push_back(20'h0F0F0);
        wait_idle(2000);
        check_rx("long_low");

        for (int r = 0; r < 3; r++) begin
            logic [19:0] d;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                d = 20'($urandom);
                exp_q.push_back(d);
                send(d, $urandom_range(16, 30), $urandom_range(2, 12));
            end
            wait_idle(n * 900 + 1000);
            check_rx("rand");
            check("rand_ovf", 32'(ovf_cnt), 32'd0);
        end

        for (int i = 0; i < 18; i++) begin
            logic [19:0] d;
            d = 20'(32'h100 * i + 32'h3000 + i);
            if (i < 17) exp_q.push_back(d);
            send(d, 16, 4);
        end
        repeat (5) @(negedge clk);
        check("ovf_level", 32'(fifo_level), 32'd16);
        check("ovf_cnt", 32'(ovf_cnt), 32'd1);
        wait_idle(20000);
        check_rx("ovf_order");

        send(20'h10000, 16, 4);
        send(20'h2AAAA, 16, 4);
        send(20'h35555, 16, 4);
        repeat (300) @(negedge clk);
        check("mid_tx_low", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("mid_rst_ovf", 32'(ovf_cnt), 32'd0);
        rx_q.delete();
        send(20'h7E1C3, 16, 4);
        exp_q.push_back(20'h7E1C3);
        wait_idle(2000);
        check_rx("post_rst");

        @(negedge clk);
        in_dval_n = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        in_dval_n = 1'b1;
        repeat (200) @(negedge clk);
        check("low_at_rel_rx", 32'(rx_q.size()), 32'd0);
        check("low_at_rel_level", 32'(fifo_level), 32'd0);

        for (int i = 0; i < 300; i++) begin
            send(20'($urandom), 16, 4);
        end
        repeat (5) @(negedge clk);
        check("ovf_sat", 32'(ovf_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
